// File: rtl/myled_pwm_axi_slave.sv
// myLED AXI4-Lite slave: four RW registers driving per-LED 8-bit PWM dimming.
// Define MYLED_BLINK_EN to add blink gating controlled by the 0xC register.
module myled_pwm_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int C_NUM_LEDS         = 4
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic [C_NUM_LEDS-1:0]           led_o
);

    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int NB = DW / 8;

    logic [3:0][DW-1:0]    reg_q, reg_d;
    logic                  awready_q, awready_d;
    logic                  bvalid_q, bvalid_d;
    logic                  arready_q, arready_d;
    logic                  rvalid_q, rvalid_d;
    logic [DW-1:0]         rdata_q, rdata_d;
    logic [15:0]           presc_cnt_q, presc_cnt_d;
    logic [7:0]            pwm_cnt_q, pwm_cnt_d;
    logic [C_NUM_LEDS-1:0] led_q, led_d, gate;
    logic                  wr_fire, rd_fire, enable, tick;
    logic [1:0]            wr_idx, rd_idx;
    logic                  unused_bits;

    assign unused_bits = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign wr_idx  = S_AXI_AWADDR[3:2];
    assign rd_idx  = S_AXI_ARADDR[3:2];
    assign wr_fire = awready_q & S_AXI_AWVALID & S_AXI_WVALID;
    assign rd_fire = arready_q & S_AXI_ARVALID;
    assign enable  = reg_q[0][0];
    assign tick    = enable & (presc_cnt_q == 16'd0);

    // Ready strobes are registered one-cycle pulses; the transfer happens on the edge they are high.
    always_comb begin
        awready_d = S_AXI_AWVALID & S_AXI_WVALID & ~bvalid_q & ~awready_q;
        arready_d = S_AXI_ARVALID & ~rvalid_q & ~arready_q;
        bvalid_d  = bvalid_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        reg_d     = reg_q;
        if (wr_fire) begin
            bvalid_d = 1'b1;
        end else if (S_AXI_BREADY) begin
            bvalid_d = 1'b0;
        end
        if (rd_fire) begin
            rvalid_d = 1'b1;
            rdata_d  = reg_q[rd_idx];
        end else if (S_AXI_RREADY) begin
            rvalid_d = 1'b0;
        end
        if (wr_fire) begin
            for (int b = 0; b < NB; b++) begin
                if (S_AXI_WSTRB[b]) begin
                    reg_d[wr_idx][8*b +: 8] = S_AXI_WDATA[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        presc_cnt_d = '0;
        pwm_cnt_d   = '0;
        if (enable) begin
            presc_cnt_d = tick ? reg_q[2][15:0] : presc_cnt_q - 16'd1;
            pwm_cnt_d   = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
        end
        for (int n = 0; n < C_NUM_LEDS; n++) begin
            led_d[n] = enable & (pwm_cnt_q < reg_q[1][8*n +: 8]) & gate[n];
        end
    end

`ifdef MYLED_BLINK_EN
    logic [23:0] blink_cnt_q, blink_cnt_d;
    logic        phase_q, phase_d, wrap;

    assign wrap = tick & (pwm_cnt_q == 8'hFF);

    // A zero half-period never matches, so the phase stays on.
    always_comb begin
        blink_cnt_d = '0;
        phase_d     = phase_q;
        gate        = '1;
        if (enable) begin
            blink_cnt_d = blink_cnt_q;
            if (wrap) begin
                if ((reg_q[3][23:0] != 24'd0) && (blink_cnt_q + 24'd1 == reg_q[3][23:0])) begin
                    blink_cnt_d = '0;
                    phase_d     = ~phase_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 24'd1;
                end
            end
        end
        for (int n = 0; n < C_NUM_LEDS; n++) begin
            gate[n] = ~reg_q[3][28+n] | phase_q;
        end
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b1;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
        end
    end
`else
    assign gate = '1;
`endif

    always_ff @(posedge S_AXI_ACLK) begin
        if (!S_AXI_ARESETN) begin
            reg_q       <= '0;
            awready_q   <= 1'b0;
            bvalid_q    <= 1'b0;
            arready_q   <= 1'b0;
            rvalid_q    <= 1'b0;
            rdata_q     <= '0;
            presc_cnt_q <= '0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
        end else begin
            reg_q       <= reg_d;
            awready_q   <= awready_d;
            bvalid_q    <= bvalid_d;
            arready_q   <= arready_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            presc_cnt_q <= presc_cnt_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = awready_q;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid_q;
    assign led_o         = led_q;

endmodule

// File: tb/tb_myled_pwm_axi_slave.sv
// Self-checking bench for myled_pwm_axi_slave: directed AXI traffic plus an arithmetic LED model.
// Blink expectations follow MYLED_BLINK_EN exactly as the design build does.
module tb_myled_pwm_axi_slave;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b1;
    logic [3:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b1;
    logic [3:0]  led_o;

    myled_pwm_axi_slave dut (
        .S_AXI_ACLK    (aclk),
        .S_AXI_ARESETN (aresetn),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .led_o         (led_o)
    );

    always #5 aclk = ~aclk;

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Model configuration as last programmed by the bench, and the cycle the enable landed.
    logic [15:0] m_presc = '0;
    logic [31:0] m_duty  = '0;
    logic [31:0] m_blink = '0;
    int          en_start = 0;
    int          last_hs = 0;
    bit          cmp_en = 1'b0;
    int          hi[4];

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // LED state k cycles after enable: PWM count is the number of prescaler ticks so far,
    // wraps are whole 256-tick periods, and the blink phase flips every half-period of wraps.
    function automatic logic [3:0] exp_led(input int k);
        logic [3:0] r;
        longint     j, total, pwm, wraps, half;
        bit         phase;
        r = '0;
        if (k >= 1) begin
            j     = longint'(k - 1);
            total = (j + longint'(m_presc)) / (longint'(m_presc) + 1);
            pwm   = total % 256;
            wraps = total / 256;
            half  = longint'(m_blink[23:0]);
            phase = 1'b1;
`ifdef MYLED_BLINK_EN
            if (half != 0) phase = ((wraps / half) % 2) == 0;
`endif
            for (int n = 0; n < 4; n++) begin
                r[n] = (pwm < longint'(m_duty[8*n +: 8])) && (!m_blink[28+n] || phase);
            end
        end
        return r;
    endfunction

    always @(negedge aclk) begin
        if (cmp_en) check_output("led_model", 32'(led_o), 32'(exp_led(cyc - en_start)));
    end

    task automatic issue_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int n;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!awready && n < 50);
        check_output("awready", 32'(awready), 32'(1));
        check_output("wready", 32'(wready), 32'(1));
        @(posedge aclk); #1;
        awvalid = 1'b0; wvalid = 1'b0;
        last_hs = cyc;
    endtask

    task automatic wait_bresp();
        int n;
        n = 0;
        do begin @(negedge aclk); n++; end while (!bvalid && n < 50);
        check_output("bvalid", 32'(bvalid), 32'(1));
        check_output("bresp", 32'(bresp), 32'(0));
        if (bready) begin @(posedge aclk); #1; end
    endtask

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb);
        issue_write(addr, data, strb);
        wait_bresp();
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        int n;
        araddr = addr; arvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 50);
        check_output("arready", 32'(arready), 32'(1));
        @(posedge aclk); #1;
        arvalid = 1'b0;
        n = 0;
        do begin @(negedge aclk); n++; end while (!rvalid && n < 50);
        check_output("rvalid", 32'(rvalid), 32'(1));
        check_output("rresp", 32'(rresp), 32'(0));
        data = rdata;
        @(posedge aclk); #1;
    endtask

    task automatic start_model(input logic [15:0] presc, input logic [31:0] duty, input logic [31:0] blink);
        axi_write(4'h8, {16'h0, presc}, 4'hF);
        axi_write(4'h4, duty, 4'hF);
        axi_write(4'hC, blink, 4'hF);
        m_presc = presc; m_duty = duty; m_blink = blink;
        issue_write(4'h0, 32'h1, 4'hF);
        en_start = last_hs;
        cmp_en = 1'b1;
        wait_bresp();
    endtask

    task automatic stop_model();
        @(posedge aclk); #1;
        cmp_en = 1'b0;
        axi_write(4'h0, 32'h0, 4'hF);
    endtask

    task automatic count_leds(input int ncyc);
        for (int n = 0; n < 4; n++) hi[n] = 0;
        repeat (ncyc) begin
            @(negedge aclk);
            for (int n = 0; n < 4; n++) hi[n] += int'(led_o[n]);
        end
    endtask

    logic [31:0] rw_data [4] = '{32'h0101FFFF, 32'hABCD0001, 32'hDEAD0011, 32'hBEEF0011};

    initial begin
        logic [31:0] rd;
        int n;

        // Reset state
        repeat (3) @(negedge aclk);
        check_output("rst_awready", 32'(awready), 32'(0));
        check_output("rst_bvalid", 32'(bvalid), 32'(0));
        check_output("rst_arready", 32'(arready), 32'(0));
        check_output("rst_rvalid", 32'(rvalid), 32'(0));
        check_output("rst_rdata", rdata, 32'h0);
        check_output("rst_led", 32'(led_o), 32'(0));
        aresetn = 1'b1;
        @(posedge aclk); #1;

        // Register write/readback
        for (int i = 0; i < 4; i++) begin
            axi_write(4'(i * 4), rw_data[i], 4'hF);
            axi_read(4'(i * 4), rd);
            check_output($sformatf("reg_rw_%0d", i), rd, rw_data[i]);
        end
        axi_write(4'h0, 32'h0, 4'hF);

        // Byte strobes
        axi_write(4'h4, 32'hFFFFFFFF, 4'hF);
        axi_write(4'h4, 32'h0000AB00, 4'b0010);
        axi_read(4'h4, rd);
        check_output("wstrb_merge", rd, 32'hFFFFABFF);

        // Simultaneous read and write of the same register returns the old value
        araddr = 4'h8; arvalid = 1'b1;
        awaddr = 4'h8; wdata = 32'h55AA1234; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        n = 0;
        do begin @(negedge aclk); n++; end while (!arready && n < 50);
        check_output("simul_arready", 32'(arready), 32'(1));
        check_output("simul_awready", 32'(awready), 32'(1));
        @(posedge aclk); #1;
        arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
        @(negedge aclk);
        check_output("simul_rvalid", 32'(rvalid), 32'(1));
        check_output("simul_bvalid", 32'(bvalid), 32'(1));
        check_output("simul_old_data", rdata, 32'hDEAD0011);
        @(posedge aclk); #1;
        axi_read(4'h8, rd);
        check_output("simul_new_data", rd, 32'h55AA1234);

        // BREADY held low: BVALID holds and no second write is accepted
        bready = 1'b0;
        issue_write(4'h8, 32'h00001111, 4'hF);
        wait_bresp();
        awaddr = 4'h8; wdata = 32'h00002222; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge aclk);
            check_output("hold_bvalid", 32'(bvalid), 32'(1));
            check_output("hold_awready", 32'(awready), 32'(0));
        end
        bready = 1'b1;
        @(negedge aclk);
        check_output("release_bvalid", 32'(bvalid), 32'(0));
        check_output("release_awready", 32'(awready), 32'(0));
        axi_write(4'h8, 32'h00002222, 4'hF);
        axi_read(4'h8, rd);
        check_output("hold_second_data", rd, 32'h00002222);

        // PWM, prescaler 0
        start_model(16'd0, 32'h00FF8000, 32'h0);
        count_leds(1024);
        check_output("pwmA_led0", 32'(hi[0]), 32'd0);
        check_output("pwmA_led1", 32'(hi[1]), 32'd512);
        check_output("pwmA_led2", 32'(hi[2]), 32'd1020);
        check_output("pwmA_led3", 32'(hi[3]), 32'd0);
        stop_model();

        // PWM, prescaler 2 (768-cycle period)
        start_model(16'd2, 32'h40C00120, 32'h0);
        count_leds(1536);
        check_output("pwmB_led0", 32'(hi[0]), 32'd192);
        check_output("pwmB_led1", 32'(hi[1]), 32'd6);
        check_output("pwmB_led2", 32'(hi[2]), 32'd1152);
        check_output("pwmB_led3", 32'(hi[3]), 32'd384);
        stop_model();

        // Blink mask on LED0, half-period of 2 PWM periods
        start_model(16'd0, 32'hFFFFFFFF, 32'h10000002);
        do @(negedge aclk); while (cyc - en_start < 1024);
        count_leds(512);
        check_output("blink_on_led0", 32'(hi[0]), 32'd510);
        check_output("blink_on_led1", 32'(hi[1]), 32'd510);
        count_leds(512);
`ifdef MYLED_BLINK_EN
        check_output("blink_off_led0", 32'(hi[0]), 32'd0);
`else
        check_output("blink_off_led0", 32'(hi[0]), 32'd510);
`endif
        check_output("blink_off_led1", 32'(hi[1]), 32'd510);
        stop_model();

        // Reset in the middle of a pending write response with LEDs lit
        start_model(16'd0, 32'hFFFFFFFF, 32'h0);
        repeat (20) @(negedge aclk);
        bready = 1'b0;
        issue_write(4'hC, 32'h12345678, 4'hF);
        wait_bresp();
        check_output("pre_reset_led", 32'(led_o), 32'hF);
        aresetn = 1'b0;
        cmp_en = 1'b0;
        @(negedge aclk);
        check_output("mid_reset_bvalid", 32'(bvalid), 32'(0));
        check_output("mid_reset_led", 32'(led_o), 32'(0));
        bready = 1'b1;
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            axi_read(4'(i * 4), rd);
            check_output($sformatf("post_reset_reg_%0d", i), rd, 32'h0);
        end
        repeat (5) @(negedge aclk);
        check_output("post_reset_led", 32'(led_o), 32'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
